instr_encoder: RTL



---
 rtl/rv_isa_pkg.sv | 40 ++++
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_fifo2.sv | 53 +++++
 rtl/instr_encoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RV32I definitions: opcodes (common with the decoder), NOP word,
// encoder FSM state encodings and the {addr, word} buffer entry type.
package rv_isa_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned STATE_W = 2;

    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_STREAM = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE   = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] word;
    } imem_entry_t;

    // True when v is representable as a w-bit two's-complement value.
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned w);
        logic [XLEN-1:0] s;
        s = XLEN'($signed(v) >>> (w - 1));
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of instr_encoder.
//   master: field source / word sink (harness side)
//   slave : encoder side
interface instr_encoder_if;
    import rv_isa_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     opcode_in;
    logic [REG_W-1:0]    rd_sel_in;
    logic [REG_W-1:0]    rs1_sel_in;
    logic [REG_W-1:0]    rs2_sel_in;
    logic [F3_W-1:0]     funct3_in;
    logic [F7_W-1:0]     funct7_in;
    logic [XLEN-1:0]     imm_value_in;
    logic [XLEN-1:0]     instr_out;
    logic [XLEN-1:0]     instr_addr_out;
    logic                instr_valid;
    logic                instr_ready;

    modport master (
        output in_valid, opcode_in, rd_sel_in, rs1_sel_in, rs2_sel_in,
               funct3_in, funct7_in, imm_value_in, instr_ready,
        input  in_ready, instr_out, instr_addr_out, instr_valid
    );

    modport slave (
        input  in_valid, opcode_in, rd_sel_in, rs1_sel_in, rs2_sel_in,
               funct3_in, funct7_in, imm_value_in, instr_ready,
        output in_ready, instr_out, instr_addr_out, instr_valid
    );

endinterface

// File: rtl/instr_fifo2.sv
// Two-entry {addr, word} FIFO. Entry 0 is always the head, so the head
// output is a register; it is cleared whenever the FIFO becomes empty.
//   clk, rst : clock, synchronous active-high reset
//   push, din: write strobe and entry (never pushed when count==2)
//   pop      : read strobe (never popped when count==0)
//   head     : oldest entry (zero when empty)
//   count    : occupancy 0..2
module instr_fifo2
    import rv_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  imem_entry_t din,
    input  logic        pop,
    output imem_entry_t head,
    output logic [1:0]  count
);

    imem_entry_t tail_q;

    // Shift-register style storage: tail moves into head on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail_q <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail_q <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head   <= (count == 2'd2) ? tail_q : '0;
                    tail_q <= '0;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head   <= tail_q;
                        tail_q <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field bundles into 32-bit words and
// streams them, tagged with their imem byte address, through a 2-entry
// buffer. Optional macro INSTR_ENCODER_RANGE_CHECK_EN turns out-of-range
// immediates into NOP + illegal_flag instead of silent truncation.
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle pulse opening a session (IDLE/DONE only)
//   bus          : field input stream and encoded word output stream
//   done         : session complete and buffer drained
//   illegal_flag : sticky per session; unsupported/invalid bundle seen
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned     DEPTH_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic            done,
    output logic            illegal_flag
);

    localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);

    // Returns {bad, word}; bad bundles encode as NOP.
    function automatic logic [XLEN:0] encode(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic [F3_W-1:0]  f3,
        input logic [F7_W-1:0]  f7,
        input logic [XLEN-1:0]  imm
    );
        logic [XLEN-1:0] w;
        logic            bad;
        w   = NOP_WORD;
        bad = 1'b0;
        case (op)
            OP_R: w = {f7, rs2, rs1, f3, rd, op};
            OP_IMM, OP_LOAD, OP_JALR: begin
                // Shift-immediate forms carry funct7 above a 5-bit shamt.
                if (op == OP_IMM && (f3 == 3'b001 || f3 == 3'b101))
                    w = {f7, imm[4:0], rs1, f3, rd, op};
                else
                    w = {imm[11:0], rs1, f3, rd, op};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                bad = !fits_signed(imm, 12);
`endif
            end
            OP_STORE: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                bad = !fits_signed(imm, 12);
`endif
            end
            OP_BRANCH: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                bad = !fits_signed(imm, 13) || imm[0];
`endif
            end
            OP_LUI, OP_AUIPC: begin
                w = {imm[31:12], rd, op};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                bad = (imm[11:0] != 12'd0);
`endif
            end
            OP_JAL: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
                bad = !fits_signed(imm, 21) || imm[0];
`endif
            end
            default: bad = 1'b1;
        endcase
        if (bad) w = NOP_WORD;
        return {bad, w};
    endfunction

    logic [STATE_W-1:0] state_q, state_nxt;
    logic [XLEN-1:0]    addr_q, addr_nxt;
    logic [CNT_W-1:0]   count_q, count_nxt;
    logic               illegal_nxt;
    logic               in_ready_q, in_ready_nxt;
    logic               done_nxt;
    logic [XLEN:0]      enc_c;
    logic [2:0]         occ_nxt;
    logic               accept_c;
    logic               pop_c;
    imem_entry_t        push_entry;
    imem_entry_t        head;
    logic [1:0]         fifo_count;

    assign accept_c = bus.in_valid && in_ready_q;
    assign pop_c    = bus.instr_valid && bus.instr_ready;

    // State register plus registered in_ready/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= BASE_ADDR;
            count_q      <= '0;
            illegal_flag <= 1'b0;
            in_ready_q   <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            addr_q       <= addr_nxt;
            count_q      <= count_nxt;
            illegal_flag <= illegal_nxt;
            in_ready_q   <= in_ready_nxt;
            done         <= done_nxt;
        end
    end

    // Next-state, session counters and look-ahead handshake outputs.
    always_comb begin
        state_nxt   = state_q;
        addr_nxt    = addr_q;
        count_nxt   = count_q;
        illegal_nxt = illegal_flag;
        enc_c       = encode(bus.opcode_in, bus.rd_sel_in, bus.rs1_sel_in,
                             bus.rs2_sel_in, bus.funct3_in, bus.funct7_in,
                             bus.imm_value_in);
        push_entry  = '{addr: addr_q, word: enc_c[XLEN-1:0]};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt   = ST_STREAM;
                    addr_nxt    = BASE_ADDR;
                    count_nxt   = '0;
                    illegal_nxt = 1'b0;
                end
            end
            ST_STREAM: begin
                if (accept_c) begin
                    addr_nxt    = addr_q + 32'd4;
                    count_nxt   = count_q + CNT_W'(1);
                    illegal_nxt = illegal_flag | enc_c[XLEN];
                    if (count_nxt == CNT_W'(DEPTH_WORDS)) state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        occ_nxt      = 3'(fifo_count) + 3'(accept_c) - 3'(pop_c);
        in_ready_nxt = (state_nxt == ST_STREAM) && (occ_nxt < 3'd2);
        done_nxt     = (state_nxt == ST_DONE) && (occ_nxt == 3'd0);
    end

    instr_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_c),
        .din   (push_entry),
        .pop   (pop_c),
        .head  (head),
        .count (fifo_count)
    );

    assign bus.in_ready       = in_ready_q;
    assign bus.instr_valid    = (fifo_count != 2'd0);
    assign bus.instr_out      = head.word;
    assign bus.instr_addr_out = head.addr;

endmodule
